// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder sequencer.
// ref_add is the arithmetic reference for the default operand width.
package serial_add_pkg;

  localparam int STATE_W   = 2;
  localparam int DEF_WIDTH = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  function automatic logic [DEF_WIDTH:0] ref_add(input logic [DEF_WIDTH-1:0] a,
                                                 input logic [DEF_WIDTH-1:0] b,
                                                 input logic                 cin);
    return {1'b0, a} + {1'b0, b} + {{DEF_WIDTH{1'b0}}, cin};
  endfunction

endpackage

// File: rtl/serial_add_seq_fa_slice.sv
// Combinational 1-bit full adder; zero latency, no flow control.
// All state, including the carry between bits, lives in the caller.
module fa_slice (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial adder: one bit pair per cycle through fa_slice, LSB first; WIDTH cycles to done.
// No backpressure: start is taken in IDLE or DONE only and ignored while busy.
module serial_add_seq
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] r_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             slice_s;
  logic             slice_co;
  logic             load;
  logic             step;
  logic             last;

  fa_slice u_slice (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (slice_s),
    .co (slice_co)
  );

  // Sum bits enter at the MSB so the register is LSB-aligned after WIDTH steps.
  generate
    if (WIDTH == 1) begin : g_r_one
      assign r_nxt = slice_s;
    end else begin : g_r_wide
      assign r_nxt = {slice_s, r_sh[WIDTH-1:1]};
    end
  endgenerate

  assign last = (cnt == CW'(WIDTH - 1));
  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        step = 1'b1;
        if (last) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = ST_RUN;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      a_sh     <= '0;
      b_sh     <= '0;
      r_sh     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      sum_out  <= '0;
      cout_out <= 1'b0;
    end else if (load) begin
      a_sh  <= a_in;
      b_sh  <= b_in;
      r_sh  <= '0;
      carry <= cin_in;
      cnt   <= '0;
    end else if (step) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      r_sh  <= r_nxt;
      carry <= slice_co;
      cnt   <= cnt + CW'(1);
      if (last) begin
        sum_out  <= r_nxt;
        cout_out <= slice_co;
      end
    end
  end

endmodule

// File: tb/tb_serial_add_seq.sv
// Directed and random bench for serial_add_seq at WIDTH=8, checked against plain arithmetic.
module tb_serial_add_seq;
  import serial_add_pkg::*;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sum_out;
  logic         cout_out;

  int           total = 0;
  int           bad   = 0;
  logic [W:0]   held;

  serial_add_seq #(.WIDTH(W)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .a_in     (a_in),
    .b_in     (b_in),
    .cin_in   (cin_in),
    .busy     (busy),
    .done     (done),
    .sum_out  (sum_out),
    .cout_out (cout_out)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ":busy"}, 33'(busy), 33'd0);
    chk({tag, ":done"}, 33'(done), 33'd0);
    chk({tag, ":result"}, 33'({cout_out, sum_out}), 33'(held));
  endtask

  // One full operation from IDLE; optional stray start pulse during RUN.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input int pulse_at, input string tag);
    logic [W:0] exp;
    exp = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    chk({tag, ":ref_add"}, 33'(ref_add(a, b, c)), 33'(exp));
    a_in   = a;
    b_in   = b;
    cin_in = c;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    a_in   = W'($urandom);
    b_in   = W'($urandom);
    cin_in = ~c;
    for (int i = 0; i < W; i++) begin
      chk({tag, ":busy_run"}, 33'(busy), 33'd1);
      chk({tag, ":done_run"}, 33'(done), 33'd0);
      chk({tag, ":hold_run"}, 33'({cout_out, sum_out}), 33'(held));
      if (i == pulse_at) begin
        start = 1'b1;
        a_in  = W'($urandom);
        b_in  = W'($urandom);
      end
      tick();
      start = 1'b0;
    end
    chk({tag, ":done"}, 33'(done), 33'd1);
    chk({tag, ":busy_done"}, 33'(busy), 33'd0);
    chk({tag, ":result"}, 33'({cout_out, sum_out}), 33'(exp));
    held = exp;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle({tag, ":after"});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    a_in   = '0;
    b_in   = '0;
    cin_in = 1'b0;
    held   = '0;
    tick();
    tick();
    reset = 1'b0;
    check_idle("reset");
    for (int i = 0; i < 10; i++) begin
      tick();
      check_idle("idle_hold");
    end

    run_op(8'hA5, 8'h5A, 1'b1, -1, "a5_5a");
    run_op(8'hFF, 8'h01, 1'b0, -1, "ff_01");
    run_op(8'h7F, 8'h01, 1'b0, -1, "7f_01");
    run_op(8'h12, 8'h34, 1'b1, 3, "ignore_start");

    // start held high: back-to-back completions every W+1 cycles
    a_in   = 8'h10;
    b_in   = 8'h20;
    cin_in = 1'b0;
    start  = 1'b1;
    tick();
    for (int rep = 0; rep < 3; rep++) begin
      for (int i = 0; i < W; i++) begin
        chk("b2b:busy_run", 33'(busy), 33'd1);
        chk("b2b:done_run", 33'(done), 33'd0);
        tick();
      end
      chk("b2b:done", 33'(done), 33'd1);
      chk("b2b:busy_done", 33'(busy), 33'd0);
      chk("b2b:result", 33'({cout_out, sum_out}), 33'h030);
      if (rep == 2) start = 1'b0;
      tick();
    end
    held = 9'h030;
    check_idle("b2b:end");

    // reset in the middle of a run aborts it and clears the result
    a_in   = 8'h0F;
    b_in   = 8'h01;
    cin_in = 1'b0;
    start  = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("abort:busy_run", 33'(busy), 33'd1);
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    held  = '0;
    check_idle("abort:reset");
    for (int i = 0; i < W + 2; i++) begin
      tick();
      check_idle("abort:no_done");
    end
    run_op(8'h03, 8'h04, 1'b0, -1, "after_abort");

    // reset and start together: start is dropped
    reset = 1'b1;
    start = 1'b1;
    a_in  = 8'h55;
    tick();
    reset = 1'b0;
    start = 1'b0;
    held  = '0;
    check_idle("rst_start");
    tick();
    check_idle("rst_start2");

    for (int n = 0; n < 16; n++) begin
      int p;
      p = -1;
      if ($urandom_range(0, 3) == 0) p = int'($urandom_range(0, W - 1));
      run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), p, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
